// File: rtl/arm_mc_pkg.sv
// Shared definitions for the multi-cycle ARM controller: state codes,
// ALU command constants and condition-field encodings.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_CMP = 4'b1010;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Wait counter stops at its maximum instead of wrapping.
    function automatic logic [3:0] wait_inc(input logic [3:0] count);
        return (count == 4'hF) ? count : count + 4'd1;
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-field evaluation against the registered {N,Z,C,V} flags.
// The reserved 1111 code never executes.
module cond_check
    import arm_mc_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign {n, z, c, v} = Flags;

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle ARM controller: Moore FSM sequencing fetch, decode, memory,
// ALU and branch steps, with optional memory wait cycles and branch-and-link.
module multicycle_controller
    import arm_mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT       = 0,
    parameter bit          BRANCH_LINK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       LinkWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] ALUControl,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state, next_state;
    logic [3:0] wait_cnt;
    logic [3:0] flags_q;
    logic       active;
    logic [1:0] op_q;
    logic [4:0] funct_q;
    logic [3:0] rd_q;
    logic       cond_ex;
    logic       wait_done;
    logic       is_cmp;

    assign wait_done = (wait_cnt == WAIT_LAST);
    assign is_cmp    = (funct_q[4:1] == ALU_CMP);
    assign Flags     = flags_q;
    assign State     = state;

    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (wait_done) next_state = S_DECODE;
            S_DECODE: begin
                if (!cond_ex)
                    next_state = S_FETCH;
                else begin
                    case (Op)
                        OP_MEM:  next_state = S_MEMADR;
                        OP_DP:   next_state = Funct[5] ? S_EXECI : S_EXECR;
                        OP_BR:   next_state = S_BRANCH;
                        default: next_state = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: next_state = funct_q[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (wait_done) next_state = S_MEMWB;
            S_EXECR:  next_state = S_ALUWB;
            S_EXECI:  next_state = S_ALUWB;
            default:  next_state = S_FETCH;
        endcase
    end

    // 'active' holds off the first fetch until the edge after reset release,
    // and its asynchronous clear makes every strobe drop the moment reset hits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
            flags_q  <= 4'd0;
            active   <= 1'b0;
            op_q     <= 2'd0;
            funct_q  <= 5'd0;
            rd_q     <= 4'd0;
        end else if (!active) begin
            active   <= 1'b1;
            state    <= S_FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= (next_state == state) ? wait_inc(wait_cnt) : 4'd0;
            if (state == S_DECODE) begin
                op_q    <= Op;
                funct_q <= Funct[4:0];
                rd_q    <= Rd;
            end
            if ((state == S_EXECR || state == S_EXECI) && (funct_q[0] || is_cmp))
                flags_q <= ALUFlags;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        LinkWrite  = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = op_q;
        RegSrc     = {op_q == OP_MEM, op_q == OP_BR};
        ALUControl = ALU_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ImmSrc    = 2'b00;
                RegSrc    = 2'b00;
                IRWrite   = active & wait_done;
                PCWrite   = active & wait_done;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ImmSrc    = Op;
                RegSrc    = {Op == OP_MEM, Op == OP_BR};
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                PCWrite   = (rd_q == 4'd15);
                RegWrite  = (rd_q != 4'd15);
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcB    = 2'b00;
                ALUControl = funct_q[4:1];
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = funct_q[4:1];
            end
            S_ALUWB: begin
                PCWrite  = !is_cmp && (rd_q == 4'd15);
                RegWrite = !is_cmp && (rd_q != 4'd15);
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                LinkWrite = BRANCH_LINK_EN && funct_q[4];
            end
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_WAIT, default 0, extra wait cycles spent in FETCH and MEMRD before the memory result is taken (0..15).
REQ-002 Parameter BRANCH_LINK_EN, default 1, enables BL (Funct[4]=1 with Op=10) writing the return address to R14.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Cond  input  4  instruction condition field; Op  input  2; Funct  input  6; Rd  input  4.
REQ-006 ALUFlags  input  4  {N,Z,C,V} from the datapath ALU for the current cycle.
REQ-007 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, LinkWrite  output  1 each  datapath strobes and selects.
REQ-008 ResultSrc  output  2; ALUSrcB  output  2; ImmSrc  output  2; RegSrc  output  2; ALUControl  output  4.
REQ-009 Flags  output  4  registered {N,Z,C,V}; State  output  4  current FSM state, for debug.

Function
REQ-010 States, with State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-011 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD(0100), ResultSrc=10; stays MEM_WAIT extra cycles; in its last cycle it asserts IRWrite and PCWrite, then goes to DECODE.
REQ-012 DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10 (PC+8); ImmSrc=Op; RegSrc[0]=(Op==10), RegSrc[1]=(Op==01).
REQ-013 Condition evaluation happens in DECODE against registered Flags and covers all ARM codes EQ..AL; Cond=1111 evaluates false.
REQ-014 DECODE on false condition -> FETCH, with no register, memory, PC or flag write.
REQ-015 DECODE on true condition: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH (no-op).
REQ-016 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD; Funct[0]=1 (LDR) -> MEMRD, else MEMWR.
REQ-017 MEMRD: AdrSrc=1, held MEM_WAIT+1 cycles, then -> MEMWB; MEMWB: ResultSrc=01 and RegWrite=1 (PCWrite instead when Rd=15), then -> FETCH.
REQ-018 MEMWR: AdrSrc=1 and MemWrite=1 for exactly one cycle, then -> FETCH.
REQ-019 EXECR/EXECI: ALUSrcA=0; ALUSrcB=00 for EXECR, 01 for EXECI; ALUControl=Funct[4:1]; then -> ALUWB.
REQ-020 ALUWB: ResultSrc=00 and RegWrite=1, or PCWrite when Rd=15; CMP (Funct[4:1]=1010) asserts no write.
REQ-021 Flags load ALUFlags at the end of EXECR/EXECI when Funct[0]=1 or the instruction is CMP; Flags never change in any other state.
REQ-022 BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=1, then -> FETCH.
REQ-023 BRANCH with BRANCH_LINK_EN=1 and Funct[4]=1: LinkWrite=1 in the same cycle, and the datapath writes PC-4 to R14.
REQ-024 All outputs are Moore, decoded from state plus latched decode fields; in every state not listed above, each strobe is 0.
REQ-025 The wait counter is 4 bits, clears on each state entry, and never wraps; with MEM_WAIT=0 it is unused.

Reset
REQ-026 reset low asynchronously forces State=FETCH, Flags=0000 and wait counter=0, with all strobes 0 while reset is held.
REQ-027 Reset asserted mid-instruction (any state) aborts that instruction with no partial write; the first fetch starts on the first rising edge after deassertion.

Structure
REQ-028 The state encodings, the ALUControl ADD/CMP constants and the condition-code constants SHALL live in the shared package arm_mc_pkg.
REQ-029 Condition evaluation SHALL be a sub-module cond_check: inputs Cond and Flags, output CondEx.
REQ-030 The block SHALL replace the single-cycle controller within the multi-cycle computer top, with the datapath unchanged apart from the IR, the data register and the multi-cycle muxes.

Verification
REQ-031 Reset held 3 cycles, then released: State=0 on the first edge, IRWrite=PCWrite=1, Flags=0000.
REQ-032 ADDS R1,R2,R3 producing zero (ALUFlags=0100): sequence 0->1->6->8->0, RegWrite=1 in ALUWB, then Flags=0100.
REQ-033 BEQ with Flags Z=1 (Cond=0000): sequence 0->1->9->0 with PCWrite in BRANCH; the same instruction with Z=0 gives 0->1->0 with no strobes.
REQ-034 LDR with MEM_WAIT=2: FETCH lasts 3 cycles, MEMRD lasts 3 cycles, sequence 0->1->2->3->4->0, RegWrite=1 only in MEMWB.
REQ-035 STR: MemWrite=1 for exactly 1 cycle in state 5; CMP sets Flags with RegWrite=0 throughout.
REQ-036 Reset pulsed low during MEMWR: MemWrite drops immediately, State=0, and no register write occurs.
